// File: rtl/item_table_arbiter.sv
// Item table arbiter: a 16-entry table shared by two rope clients under an exclusive grant,
// with a free-running drawer read port and a loader write port that is active only while idle.
module item_table_arbiter #(
   parameter int TIMEOUT = 1024
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        c0_read_req,
   input  logic        c0_write_req,
   input  logic [3:0]  c0_address,
   input  logic [31:0] c0_write_data,
   input  logic        c0_release,
   output logic [31:0] c0_read_data,
   output logic        c0_read_done,
   output logic        c0_write_done,
   input  logic        c1_read_req,
   input  logic        c1_write_req,
   input  logic [3:0]  c1_address,
   input  logic [31:0] c1_write_data,
   input  logic        c1_release,
   output logic [31:0] c1_read_data,
   output logic        c1_read_done,
   output logic        c1_write_done,
   input  logic [3:0]  disp_address,
   output logic [31:0] disp_data,
   input  logic        load_en,
   input  logic [3:0]  load_address,
   input  logic [31:0] load_data,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   localparam bit          TO_EN_C   = (TIMEOUT != 32'sd0);
   localparam logic [10:0] TO_LAST_C = 11'(TIMEOUT - 32'sd1);
   localparam logic [10:0] CNT_MAX_C = 11'h7FF;

   state_t      state_r;
   state_t      next_s;
   logic        last_r;
   logic [10:0] cnt_r;
   logic [31:0] table_r [16];

   logic        c0_req_s;
   logic        c1_req_s;
   logic        owned_s;
   logic        o_rd_s;
   logic        o_wr_s;
   logic        o_rel_s;
   logic [3:0]  o_addr_s;
   logic [31:0] o_wdata_s;
   logic        end_s;
   logic        svc_rd_s;
   logic        svc_wr_s;
   logic        ld_we_s;

   assign c0_req_s = c0_read_req | c0_write_req;
   assign c1_req_s = c1_read_req | c1_write_req;

   // Route the current owner's request signals onto a common set of wires
   always_comb begin
      owned_s   = (state_r != ST_IDLE);
      o_rd_s    = 1'b0;
      o_wr_s    = 1'b0;
      o_rel_s   = 1'b0;
      o_addr_s  = 4'd0;
      o_wdata_s = 32'd0;
      if (state_r == ST_OWN1) begin
         o_rd_s    = c1_read_req;
         o_wr_s    = c1_write_req;
         o_rel_s   = c1_release;
         o_addr_s  = c1_address;
         o_wdata_s = c1_write_data;
      end else begin
         o_rd_s    = c0_read_req;
         o_wr_s    = c0_write_req;
         o_rel_s   = c0_release;
         o_addr_s  = c0_address;
         o_wdata_s = c0_write_data;
      end
      // A forced timeout behaves exactly like an owner release
      end_s = owned_s && (o_rel_s || (TO_EN_C && (cnt_r == TO_LAST_C)));
   end

   // State register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state: grant from idle (tie goes to the client not served last), release back to idle
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!load_en && (c0_req_s || c1_req_s)) begin
               if (c0_req_s && c1_req_s) begin
                  next_s = last_r ? ST_OWN0 : ST_OWN1;
               end else if (c0_req_s) begin
                  next_s = ST_OWN0;
               end else begin
                  next_s = ST_OWN1;
               end
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_OWN0, ST_OWN1: begin
            if (end_s) begin
               next_s = ST_IDLE;
            end else begin
               next_s = state_r;
            end
         end
         default: next_s = ST_IDLE;
      endcase
   end

   // Output decode: table service strobes for the owner and the loader
   always_comb begin
      svc_wr_s = owned_s && !end_s && o_wr_s;
      svc_rd_s = owned_s && !end_s && !o_wr_s && o_rd_s;
      ld_we_s  = (state_r == ST_IDLE) && load_en;
   end

   // Table, drawer port, client outputs, round-robin pointer and idle counter
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 16; i++) begin
            table_r[i] <= 32'd0;
         end
         disp_data     <= 32'd0;
         c0_read_data  <= 32'd0;
         c0_read_done  <= 1'b0;
         c0_write_done <= 1'b0;
         c1_read_data  <= 32'd0;
         c1_read_done  <= 1'b0;
         c1_write_done <= 1'b0;
         busy          <= 1'b0;
         last_r        <= 1'b1;
         cnt_r         <= 11'd0;
      end else begin
         disp_data <= table_r[disp_address];
         if (svc_wr_s) begin
            table_r[o_addr_s] <= o_wdata_s;
         end else if (ld_we_s) begin
            table_r[load_address] <= load_data;
         end
         c0_read_done  <= (state_r == ST_OWN0) && svc_rd_s;
         c0_write_done <= (state_r == ST_OWN0) && svc_wr_s;
         c1_read_done  <= (state_r == ST_OWN1) && svc_rd_s;
         c1_write_done <= (state_r == ST_OWN1) && svc_wr_s;
         if (svc_rd_s && (state_r == ST_OWN0)) begin
            c0_read_data <= table_r[o_addr_s];
         end
         if (svc_rd_s && (state_r == ST_OWN1)) begin
            c1_read_data <= table_r[o_addr_s];
         end
         busy <= (next_s != ST_IDLE);
         if (end_s) begin
            last_r <= (state_r == ST_OWN1);
         end
         if (!owned_s || end_s || o_rd_s || o_wr_s) begin
            cnt_r <= 11'd0;
         end else if (cnt_r != CNT_MAX_C) begin
            cnt_r <= cnt_r + 11'd1;
         end
      end
   end

endmodule

// File: tb/tb_item_table_arbiter.sv
// Bench for item_table_arbiter: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a transaction-level model of the arbiter rules.
module tb_item_table_arbiter;

   localparam int TO = 8;

   logic        clock = 1'b0;
   logic        resetn;
   logic        c0_read_req, c0_write_req, c0_release;
   logic [3:0]  c0_address;
   logic [31:0] c0_write_data, c0_read_data;
   logic        c0_read_done, c0_write_done;
   logic        c1_read_req, c1_write_req, c1_release;
   logic [3:0]  c1_address;
   logic [31:0] c1_write_data, c1_read_data;
   logic        c1_read_done, c1_write_done;
   logic [3:0]  disp_address, load_address;
   logic [31:0] disp_data, load_data;
   logic        load_en, busy;

   int checks = 0;
   int failures = 0;

   // model state
   int          m_owner;
   int          m_last;
   int          m_idle;
   logic [31:0] m_tbl [16];
   logic [31:0] e_rdata [2];
   logic        e_rdone [2];
   logic        e_wdone [2];
   logic [31:0] e_disp;
   logic        e_busy;

   item_table_arbiter #(.TIMEOUT(TO)) dut (
      .clock(clock), .resetn(resetn),
      .c0_read_req(c0_read_req), .c0_write_req(c0_write_req), .c0_address(c0_address),
      .c0_write_data(c0_write_data), .c0_release(c0_release), .c0_read_data(c0_read_data),
      .c0_read_done(c0_read_done), .c0_write_done(c0_write_done),
      .c1_read_req(c1_read_req), .c1_write_req(c1_write_req), .c1_address(c1_address),
      .c1_write_data(c1_write_data), .c1_release(c1_release), .c1_read_data(c1_read_data),
      .c1_read_done(c1_read_done), .c1_write_done(c1_write_done),
      .disp_address(disp_address), .disp_data(disp_data),
      .load_en(load_en), .load_address(load_address), .load_data(load_data),
      .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = 1;
      m_idle  = 0;
      for (int i = 0; i < 16; i++) m_tbl[i] = 32'd0;
      for (int k = 0; k < 2; k++) begin
         e_rdata[k] = 32'd0;
         e_rdone[k] = 1'b0;
         e_wdone[k] = 1'b0;
      end
      e_disp = 32'd0;
      e_busy = 1'b0;
   endtask

   // One clock edge of the arbiter rules, applied to the inputs currently on the pins
   task automatic model_step();
      logic        rd [2];
      logic        wr [2];
      logic        rel [2];
      logic [3:0]  ad [2];
      logic [31:0] wd [2];
      int o;
      rd[0] = c0_read_req;  wr[0] = c0_write_req; rel[0] = c0_release; ad[0] = c0_address; wd[0] = c0_write_data;
      rd[1] = c1_read_req;  wr[1] = c1_write_req; rel[1] = c1_release; ad[1] = c1_address; wd[1] = c1_write_data;
      e_disp = m_tbl[disp_address];
      if (m_owner < 0) begin
         for (int k = 0; k < 2; k++) begin
            e_rdone[k] = 1'b0;
            e_wdone[k] = 1'b0;
         end
         if (load_en) begin
            m_tbl[load_address] = load_data;
         end else if (rd[0] || wr[0] || rd[1] || wr[1]) begin
            if ((rd[0] || wr[0]) && (rd[1] || wr[1])) m_owner = (m_last == 1) ? 0 : 1;
            else m_owner = (rd[0] || wr[0]) ? 0 : 1;
            m_idle = 0;
         end
      end else begin
         o = m_owner;
         if (rel[o] || (m_idle == TO - 1)) begin
            e_rdone[o] = 1'b0;
            e_wdone[o] = 1'b0;
            m_last  = o;
            m_owner = -1;
            m_idle  = 0;
         end else begin
            e_wdone[o] = wr[o];
            e_rdone[o] = !wr[o] && rd[o];
            if (wr[o]) m_tbl[ad[o]] = wd[o];
            else if (rd[o]) e_rdata[o] = m_tbl[ad[o]];
            if (rd[o] || wr[o]) m_idle = 0;
            else if (m_idle < 2047) m_idle++;
         end
      end
      e_busy = (m_owner >= 0);
   endtask

   task automatic check_all();
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("c0_read_data", c0_read_data, e_rdata[0]);
      chk("c0_read_done", {31'd0, c0_read_done}, {31'd0, e_rdone[0]});
      chk("c0_write_done", {31'd0, c0_write_done}, {31'd0, e_wdone[0]});
      chk("c1_read_data", c1_read_data, e_rdata[1]);
      chk("c1_read_done", {31'd0, c1_read_done}, {31'd0, e_rdone[1]});
      chk("c1_write_done", {31'd0, c1_write_done}, {31'd0, e_wdone[1]});
      chk("disp_data", disp_data, e_disp);
   endtask

   // Advance one clock (inputs already set at the falling edge), then compare at the next falling edge
   task automatic cycle();
      @(posedge clock);
      if (resetn) model_step();
      @(negedge clock);
      check_all();
   endtask

   task automatic idle_inputs();
      c0_read_req = 1'b0; c0_write_req = 1'b0; c0_release = 1'b0; c0_address = 4'd0; c0_write_data = 32'd0;
      c1_read_req = 1'b0; c1_write_req = 1'b0; c1_release = 1'b0; c1_address = 4'd0; c1_write_data = 32'd0;
      load_en = 1'b0; load_address = 4'd0; load_data = 32'd0;
   endtask

   task automatic pulse_reset();
      resetn = 1'b0;
      model_reset();
      cycle();
      resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0;
      idle_inputs();
      disp_address = 4'd0;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_dones", {28'd0, c0_read_done, c0_write_done, c1_read_done, c1_write_done}, 32'd0);
      chk("reset_disp", disp_data, 32'd0);
      resetn = 1'b1;

      // load then owner read with two-cycle latency from grant
      load_en = 1'b1; load_address = 4'd3; load_data = 32'h12345006;
      cycle();
      idle_inputs();
      c0_read_req = 1'b1; c0_address = 4'd3;
      cycle();
      chk("t1_busy_grant", {31'd0, busy}, 32'd1);
      chk("t1_done_c1", {31'd0, c0_read_done}, 32'd0);
      cycle();
      chk("t1_done_c2", {31'd0, c0_read_done}, 32'd1);
      chk("t1_data_c2", c0_read_data, 32'h12345006);
      c0_read_req = 1'b0; c0_release = 1'b1;
      cycle();
      chk("t1_busy_rel", {31'd0, busy}, 32'd0);
      idle_inputs();
      cycle();

      // tie right after reset goes to c0, then to c1 after release, then back to c0
      pulse_reset();
      c0_read_req = 1'b1; c1_read_req = 1'b1; c0_address = 4'd3; c1_address = 4'd3;
      cycle();
      cycle();
      chk("t2_c0_done", {31'd0, c0_read_done}, 32'd1);
      chk("t2_c1_stall", {31'd0, c1_read_done}, 32'd0);
      c0_read_req = 1'b0; c0_release = 1'b1;
      cycle();
      c0_release = 1'b0;
      cycle();
      cycle();
      chk("t2_c1_granted", {31'd0, c1_read_done}, 32'd1);
      c1_read_req = 1'b0; c1_release = 1'b1;
      cycle();
      c1_release = 1'b0; c0_read_req = 1'b1; c1_read_req = 1'b1;
      cycle();
      cycle();
      chk("t2_tie_c0", {31'd0, c0_read_done}, 32'd1);
      chk("t2_tie_c1", {31'd0, c1_read_done}, 32'd0);
      idle_inputs();
      c0_release = 1'b1;
      cycle();
      idle_inputs();
      cycle();

      // competing writes to entry 5
      c0_write_req = 1'b1; c0_address = 4'd5; c0_write_data = 32'hAB000003;
      cycle();
      c1_write_req = 1'b1; c1_address = 4'd5; c1_write_data = 32'hFFFFFFFF;
      cycle();
      chk("t3_c0_wdone", {31'd0, c0_write_done}, 32'd1);
      chk("t3_c1_wstall", {31'd0, c1_write_done}, 32'd0);
      c0_write_req = 1'b0; c0_release = 1'b1; disp_address = 4'd5;
      cycle();
      c0_release = 1'b0;
      cycle();
      chk("t3_entry5", disp_data, 32'hAB000003);
      cycle();
      chk("t3_c1_wdone", {31'd0, c1_write_done}, 32'd1);
      cycle();
      chk("t3_entry5_c1", disp_data, 32'hFFFFFFFF);
      idle_inputs();
      c1_release = 1'b1;
      cycle();
      idle_inputs();
      cycle();

      // timeout: c0 grabs then idles; c1 waits
      c0_read_req = 1'b1;
      cycle();
      c0_read_req = 1'b0; c1_read_req = 1'b1; c1_address = 4'd5;
      for (int i = 0; i < 7; i++) cycle();
      chk("t4_busy_held", {31'd0, busy}, 32'd1);
      cycle();
      chk("t4_busy_drop", {31'd0, busy}, 32'd0);
      cycle();
      cycle();
      chk("t4_c1_done", {31'd0, c1_read_done}, 32'd1);
      chk("t4_c1_data", c1_read_data, 32'hFFFFFFFF);
      idle_inputs();
      c1_release = 1'b1;
      cycle();
      idle_inputs();
      cycle();

      // asynchronous reset in the middle of a c1 write
      c1_write_req = 1'b1; c1_address = 4'd9; c1_write_data = 32'h0BADF00D;
      cycle();
      cycle();
      #2;
      resetn = 1'b0;
      #1;
      model_reset();
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_dones", {28'd0, c0_read_done, c0_write_done, c1_read_done, c1_write_done}, 32'd0);
      chk("t5_disp", disp_data, 32'd0);
      idle_inputs();
      @(negedge clock);
      resetn = 1'b1;
      c0_read_req = 1'b1; c0_address = 4'd3;
      cycle();
      cycle();
      chk("t5_read_zero", c0_read_data, 32'd0);
      chk("t5_read_done", {31'd0, c0_read_done}, 32'd1);
      idle_inputs();
      c0_release = 1'b1;
      cycle();
      idle_inputs();

      // drawer sees old data on the write edge, new data one cycle later
      load_en = 1'b1; load_address = 4'd7; load_data = 32'hDEAD0007;
      cycle();
      idle_inputs();
      c0_write_req = 1'b1; c0_address = 4'd7; c0_write_data = 32'h00000005;
      cycle();
      disp_address = 4'd7;
      cycle();
      chk("t6_disp_old", disp_data, 32'hDEAD0007);
      c0_write_req = 1'b0;
      cycle();
      chk("t6_disp_new", disp_data, 32'h00000005);
      c0_release = 1'b1;
      cycle();
      idle_inputs();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         c0_read_req   = ($urandom_range(0, 2) == 0);
         c0_write_req  = ($urandom_range(0, 3) == 0);
         c0_release    = ($urandom_range(0, 7) == 0);
         c0_address    = 4'($urandom_range(0, 15));
         c0_write_data = $urandom;
         c1_read_req   = ($urandom_range(0, 2) == 0);
         c1_write_req  = ($urandom_range(0, 3) == 0);
         c1_release    = ($urandom_range(0, 7) == 0);
         c1_address    = 4'($urandom_range(0, 15));
         c1_write_data = $urandom;
         load_en       = ($urandom_range(0, 5) == 0);
         load_address  = 4'($urandom_range(0, 15));
         load_data     = $urandom;
         disp_address  = 4'($urandom_range(0, 15));
         if ((n % 500) == 250) pulse_reset();
         else cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
